bpsk_frame_scheduler: RTL and testbench

//  Sequences the BPSK transmit datapath. Buffers UART-received bytes and decides when to open a frame.

---
 rtl/bpsk_pkg.sv | 16 +
 rtl/bpsk_byte_fifo.sv | 58 +++++
 rtl/bpsk_frame_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_bpsk_frame_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmit frame scheduler.
package bpsk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StLen,
    StPayload,
    StCheck
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE     = 8'hAA;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD3;

endpackage

// File: rtl/bpsk_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
module bpsk_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage array, no reset needed: contents are only read when count > 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bpsk_frame_scheduler.sv
// Buffers received bytes and emits framed, symbol-paced, MSB-first bit stream:
// preamble, sync, length, payload, XOR checksum.
module bpsk_frame_scheduler
  import bpsk_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter int unsigned PREAMBLE_BYTES = 2,
  parameter logic [7:0]  SYNC_WORD      = DEFAULT_SYNC_WORD,
  parameter int unsigned SYMBOL_DIV     = 16,
  parameter int unsigned IDLE_TIMEOUT   = 1024
) (
  input  logic                          sysclk_i,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic                          sym_bit_o,
  output logic                          sym_valid_o,
  output logic                          tx_active_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W = $clog2(SYMBOL_DIV);
  localparam int unsigned TO_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CW-1:0]    MaxCnt  = CW'(MAX_PAYLOAD);
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(SYMBOL_DIV - 1);
  localparam logic [TO_W-1:0]  ToMax   = TO_W'(IDLE_TIMEOUT);
  localparam logic [7:0]       PreLast = 8'(PREAMBLE_BYTES - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       chk_q, chk_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             done_q, done_d;

  logic             fifo_full, fifo_empty, accept, pop, start, sym_end, byte_end;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;

  bpsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sysclk_i),
    .rst_n   (rst_n),
    .push_i  (in_valid_i),
    .wdata_i (in_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready_o   = ~fifo_full;
  assign accept       = in_valid_i & ~fifo_full;
  assign fifo_count_o = fifo_count;

  assign sym_end  = (div_q == DivLast);
  assign byte_end = sym_end && (bit_q == 3'd7);
  assign start    = (state_q == StIdle) && !fifo_empty &&
                    ((fifo_count >= MaxCnt) || (to_q == ToMax));
  // Payload byte leaves the FIFO during its first symbol; it was already
  // peeked into the shift register at the preceding byte boundary.
  assign pop      = (state_q == StPayload) && (div_q == '0) && (bit_q == 3'd0);

  assign tx_active_o  = (state_q != StIdle);
  assign sym_valid_o  = tx_active_o && (div_q == '0);
  assign sym_bit_o    = tx_active_o && shift_q[7];
  assign frame_done_o = done_q;

  // Idle timeout: cleared by any accepted byte, runs only while idle with data buffered.
  always_comb begin
    to_d = to_q;
    if (accept) begin
      to_d = '0;
    end else if ((state_q == StIdle) && !fifo_empty && (to_q != ToMax)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Frame sequencer: symbol divider, bit/byte counters and byte loading per state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    shift_d = shift_q;
    chk_d   = chk_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      if (sym_end) begin
        div_d   = '0;
        bit_d   = bit_q + 3'd1;
        shift_d = {shift_q[6:0], 1'b0};
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPreamble;
          len_d   = (fifo_count >= MaxCnt) ? 8'(MAX_PAYLOAD) : 8'(fifo_count);
          div_d   = '0;
          bit_d   = 3'd0;
          byte_d  = 8'd0;
          shift_d = PREAMBLE_BYTE;
          chk_d   = 8'd0;
        end
      end
      StPreamble: begin
        if (byte_end) begin
          if (byte_q == PreLast) begin
            state_d = StSync;
            byte_d  = 8'd0;
            shift_d = SYNC_WORD;
          end else begin
            byte_d  = byte_q + 8'd1;
            shift_d = PREAMBLE_BYTE;
          end
        end
      end
      StSync: begin
        if (byte_end) begin
          state_d = StLen;
          shift_d = len_q;
        end
      end
      StLen: begin
        if (byte_end) begin
          state_d = StPayload;
          byte_d  = 8'd0;
          shift_d = fifo_rdata;
          chk_d   = chk_q ^ fifo_rdata;
        end
      end
      StPayload: begin
        if (byte_end) begin
          if (byte_q == len_q - 8'd1) begin
            state_d = StCheck;
            shift_d = chk_q;
          end else begin
            byte_d  = byte_q + 8'd1;
            shift_d = fifo_rdata;
            chk_d   = chk_q ^ fifo_rdata;
          end
        end
      end
      StCheck: begin
        if (byte_end) begin
          state_d = StIdle;
          shift_d = 8'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge sysclk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      len_q   <= 8'd0;
      shift_q <= 8'd0;
      chk_q   <= 8'd0;
      to_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      chk_q   <= chk_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Self-checking bench: byte scoreboard feeding a frame monitor, table-driven
// framing scenarios, plus hand-written mid-frame, reset and fast-divider cases.
module tb_bpsk_frame_scheduler;

  localparam int SD  = 16;
  localparam int PRE = 2;
  localparam int MAX = 16;
  localparam int TO  = 1024;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, sym_bit, sym_valid, tx_active, frame_done;
  logic [4:0] fifo_count;

  logic [7:0] in2_data;
  logic       in2_valid;
  logic       in2_ready, sym2_bit, sym2_valid, tx2_active, done2;
  logic [4:0] cnt2;

  bpsk_frame_scheduler u_dut (
    .sysclk_i     (sysclk),
    .rst_n        (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .sym_bit_o    (sym_bit),
    .sym_valid_o  (sym_valid),
    .tx_active_o  (tx_active),
    .frame_done_o (frame_done),
    .fifo_count_o (fifo_count)
  );

  bpsk_frame_scheduler #(
    .SYMBOL_DIV     (2),
    .PREAMBLE_BYTES (1)
  ) u_dut2 (
    .sysclk_i     (sysclk),
    .rst_n        (rst_n),
    .in_data_i    (in2_data),
    .in_valid_i   (in2_valid),
    .in_ready_o   (in2_ready),
    .sym_bit_o    (sym2_bit),
    .sym_valid_o  (sym2_valid),
    .tx_active_o  (tx2_active),
    .frame_done_o (done2),
    .fifo_count_o (cnt2)
  );

  initial forever #5 sysclk = ~sysclk;

  int cyc = 0;
  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic note_fail(input string name, input string act, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%s required=%s (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard queues: filled by stimulus, drained by the monitor.
  logic [7:0] data_q[$];
  int         exp_len_q[$];
  logic [7:0] exp_b[$];
  int         start_q[$];
  int         rx_len_q[$];

  bit         in_frame = 1'b0;
  logic [7:0] acc = 8'd0;
  logic [7:0] last_chk = 8'd0;
  logic       cur_bit = 1'b0;
  int         strobes = 0, last_s = 0, frames_done = 0, cur_len = 0;

  task automatic build_frame();
    logic [7:0] x, b;
    exp_b.delete();
    if (exp_len_q.size() == 0) begin
      note_fail("unexpected_frame", "frame started", "no frame pending");
      cur_len = 0;
    end else begin
      cur_len = exp_len_q.pop_front();
    end
    for (int i = 0; i < PRE; i++) exp_b.push_back(8'hAA);
    exp_b.push_back(8'hD3);
    exp_b.push_back(8'(cur_len));
    x = 8'd0;
    for (int i = 0; i < cur_len; i++) begin
      if (data_q.size() == 0) begin
        note_fail("payload_underrun", "no byte", "queued byte");
        b = 8'd0;
      end else begin
        b = data_q.pop_front();
      end
      x ^= b;
      exp_b.push_back(b);
    end
    exp_b.push_back(x);
  endtask

  // Frame monitor on DUT 1, sampled on the falling edge.
  initial forever begin
    @(negedge sysclk);
    if (!rst_n) begin
      in_frame = 1'b0;
      exp_b.delete();
    end else begin
      if (sym_valid && !in_frame) begin
        in_frame = 1'b1;
        strobes  = 0;
        start_q.push_back(cyc);
        build_frame();
      end
      if (sym_valid) begin
        chk("valid_while_active", int'(tx_active), 1);
        if (strobes > 0) chk("strobe_spacing", cyc - last_s, SD);
        last_s  = cyc;
        cur_bit = sym_bit;
        acc     = {acc[6:0], sym_bit};
        strobes++;
        if (strobes % 8 == 0) begin
          if (strobes / 8 == PRE + 2) rx_len_q.push_back(int'(acc));
          last_chk = acc;
          if (exp_b.size() == 0) note_fail("extra_byte", "byte received", "end of frame");
          else chk("frame_byte", int'(acc), int'(exp_b.pop_front()));
        end
      end else if (in_frame && tx_active) begin
        chk("sym_bit_hold", int'(sym_bit), int'(cur_bit));
      end
      if (frame_done) begin
        chk("done_in_frame", int'(in_frame), 1);
        if (in_frame) begin
          chk("symbol_count", strobes, 8 * (PRE + 3 + cur_len));
          chk("done_spacing", cyc - last_s, SD);
          chk("bytes_left", exp_b.size(), 0);
        end
        chk("tx_active_at_done", int'(tx_active), 0);
        chk("sym_bit_at_done", int'(sym_bit), 0);
        frames_done++;
        in_frame = 1'b0;
      end else if (!in_frame) begin
        chk("idle_tx_active", int'(tx_active), 0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int g = 0;
    @(negedge sysclk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 5000) begin
      @(negedge sysclk);
      g++;
    end
    if (!in_ready) begin
      note_fail("push_timeout", "in_ready low", "in_ready high");
      in_valid = 1'b0;
      acc_cyc  = -1;
    end else begin
      acc_cyc = cyc;
      data_q.push_back(b);
    end
  endtask

  task automatic release_input();
    @(negedge sysclk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int g = 0;
    while (frames_done < target && g < budget) begin
      @(negedge sysclk);
      g++;
    end
    chk("frames_completed", frames_done, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_sym_bit"}, int'(sym_bit), 0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_tx_active"}, int'(tx_active), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_fifo_count"}, int'(fifo_count), 0);
  endtask

  typedef struct {
    int                n;
    logic [19:0][7:0]  d;
    int                len0;
    int                len1;
    int                ofs;    // first strobe, cycles after the triggering accept
    logic [7:0]        chk;    // CHECK byte of the last frame
  } vec_t;

  initial begin : watchdog
    #(1_500_000);
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t v[3];
    int   a, trig, base, fd0, g, ns, txc, last2, nlen;
    logic [39:0] rx2;
    logic [39:0] exp2;

    v[0].n = 16; v[0].len0 = 16; v[0].len1 = 0; v[0].ofs = 2; v[0].chk = 8'h10;
    for (int i = 0; i < 20; i++) v[0].d[i] = 8'(i + 1);
    v[1].n = 3; v[1].len0 = 3; v[1].len1 = 0; v[1].ofs = TO + 2; v[1].chk = 8'h66;
    v[1].d = '0;
    v[1].d[0] = 8'h5A; v[1].d[1] = 8'hC3; v[1].d[2] = 8'hFF;
    v[2].n = 20; v[2].len0 = 16; v[2].len1 = 4; v[2].ofs = 2; v[2].chk = 8'h00;
    for (int i = 0; i < 20; i++) v[2].d[i] = 8'(8'h30 + i);

    rst_n     = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    in2_data  = 8'd0;
    in2_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    // Table-driven framing scenarios.
    for (int k = 0; k < 3; k++) begin
      base = start_q.size();
      fd0  = frames_done;
      trig = -1;
      exp_len_q.push_back(v[k].len0);
      if (v[k].len1 > 0) exp_len_q.push_back(v[k].len1);
      for (int i = 0; i < v[k].n; i++) begin
        push_byte(v[k].d[i], a);
        if (i == ((v[k].n < MAX) ? v[k].n : MAX) - 1) trig = a;
        if (i == MAX - 1 && v[k].n > MAX) begin
          @(negedge sysclk);
          chk("full_in_ready", int'(in_ready), 0);
          chk("full_count", int'(fifo_count), MAX);
        end
      end
      release_input();
      wait_frames(fd0 + ((v[k].len1 > 0) ? 2 : 1), 12000);
      if (start_q.size() > base) chk("start_offset", start_q[base] - trig, v[k].ofs);
      else note_fail("start_offset", "no frame", "frame start");
      chk("check_byte", int'(last_chk), int'(v[k].chk));
    end

    // Bytes arriving mid-frame are held for the following frame.
    fd0 = frames_done;
    exp_len_q.push_back(16);
    exp_len_q.push_back(5);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i), a);
    release_input();
    g = 0;
    while (!tx_active && g < 100) begin
      @(negedge sysclk);
      g++;
    end
    chk("midframe_tx_active", int'(tx_active), 1);
    for (int i = 0; i < 5; i++) push_byte(8'(8'hB0 + i), a);
    release_input();
    chk("midframe_still_first", frames_done, fd0);
    wait_frames(fd0 + 2, 12000);
    nlen = rx_len_q.size();
    if (nlen >= 2) begin
      chk("midframe_len_first", rx_len_q[nlen-2], 16);
      chk("midframe_len_next", rx_len_q[nlen-1], 5);
    end else begin
      note_fail("midframe_len", "missing LEN bytes", "two frames");
    end

    // Reset in the middle of the payload.
    fd0 = frames_done;
    exp_len_q.push_back(16);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i), a);
    release_input();
    g = 0;
    while (!(in_frame && strobes >= 8 * (PRE + 3) + 4) && g < 3000) begin
      @(negedge sysclk);
      g++;
    end
    chk("reached_payload", int'(in_frame), 1);
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (40) @(negedge sysclk);
    chk("no_done_after_reset", frames_done, fd0);
    chk("idle_after_reset", int'(tx_active), 0);
    exp_len_q.push_back(3);
    push_byte(8'h11, a);
    push_byte(8'h22, a);
    push_byte(8'h33, a);
    release_input();
    wait_frames(fd0 + 1, 4000);
    chk("refill_check_byte", int'(last_chk), 8'h00);

    // Fast divider, single preamble byte, on the second instance.
    exp2 = 40'hAA_D3_01_80_80;
    @(negedge sysclk);
    in2_data  = 8'h80;
    in2_valid = 1'b1;
    chk("dut2_ready", int'(in2_ready), 1);
    trig = cyc;
    @(negedge sysclk);
    in2_valid = 1'b0;
    g = 0;
    while (!sym2_valid && g < 3000) begin
      @(negedge sysclk);
      g++;
    end
    chk("dut2_start_offset", cyc - trig, TO + 2);
    rx2 = '0; ns = 0; txc = 0; last2 = cyc; g = 0;
    while (!done2 && g < 200) begin
      if (sym2_valid) begin
        if (ns > 0) chk("dut2_spacing", cyc - last2, 2);
        last2 = cyc;
        rx2   = {rx2[38:0], sym2_bit};
        ns++;
      end
      if (tx2_active) txc++;
      @(negedge sysclk);
      g++;
    end
    chk("dut2_done", int'(done2), 1);
    chk("dut2_symbols", ns, 40);
    chk("dut2_stream_hi", int'(rx2[39:8]), int'(exp2[39:8]));
    chk("dut2_stream_lo", int'(rx2[7:0]), int'(exp2[7:0]));
    chk("dut2_active_cycles", txc, 80);
    chk("dut2_tx_dropped", int'(tx2_active), 0);
    chk("dut2_fifo_empty", int'(cnt2), 0);

    repeat (4) @(negedge sysclk);
    chk("leftover_bytes", data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
